// File: rtl/rce_tx_pkg.sv
// Shared TX-side definitions: serializer state encoding and counter sizing helper.
package rce_tx_pkg;

    localparam int unsigned LM_DEF = 16;
    localparam int unsigned M_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_MSG = 2'd1,
        SEND_PAR = 2'd2
    } tx_state_e;

    // Bit-index counter width for the longer of the two phases (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned lm, input int unsigned m);
        int unsigned mx;
        mx = (lm > m) ? lm : m;
        return (mx < 2) ? 1 : int'($clog2(mx));
    endfunction

    localparam int unsigned CNT_W = cnt_width(LM_DEF, M_DEF);

endpackage

// File: rtl/rce_codeword_serializer_if.sv
// Parallel word input plus serial codeword output of the RCE serializer.
interface rce_codeword_serializer_if #(
    parameter int unsigned Lm = 16,
    parameter int unsigned M  = 16
);
    logic [Lm-1:0] msg;
    logic [M-1:0]  p;
    logic          load;
    logic          ready;
    logic          y;
    logic          y_valid;
    logic          y_ready;
    logic          y_last;
    logic          busy;
    logic          ovf;

    modport master (
        output msg, p, load, y_ready,
        input  ready, y, y_valid, y_last, busy, ovf
    );

    modport slave (
        input  msg, p, load, y_ready,
        output ready, y, y_valid, y_last, busy, ovf
    );
endinterface

// File: rtl/rce_word_hold.sv
// One-entry codeword hold buffer: register plus full flag.
module rce_word_hold #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    // Capture on push, release on pop; push and pop never coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rce_codeword_serializer.sv
// Serializes {msg, parity} MSB-first under valid/ready, with a one-word hold slot.
module rce_codeword_serializer
    import rce_tx_pkg::*;
#(
    parameter int unsigned Lm = 16,
    parameter int unsigned M  = 16
) (
    input  logic clk,
    input  logic rst,
    rce_codeword_serializer_if.slave bus
);

    localparam int unsigned W  = Lm + M;
    localparam int unsigned CW = cnt_width(Lm, M);
    localparam logic [CW-1:0] MSG_TOP = CW'(Lm - 1);
    localparam logic [CW-1:0] PAR_TOP = CW'(M - 1);

    tx_state_e     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0]  sh, sh_nx;
    logic          y_q, y_nx;
    logic          vld_q, vld_nx;
    logic          last_q, last_nx;
    logic          ovf_q;

    logic          hold_full;
    logic [W-1:0]  hold_data;
    logic          xfer, last_xfer, accept, load_shift, push, pop, start;
    logic [W-1:0]  new_word;

    // Handshake decode and routing of an accepted word.
    assign xfer       = vld_q & bus.y_ready;
    assign last_xfer  = xfer & (state == SEND_PAR) & (cnt == '0);
    assign accept     = bus.load & ~hold_full;
    assign load_shift = accept & ((state == IDLE) | (last_xfer & ~hold_full));
    assign pop        = last_xfer & hold_full;
    assign push       = accept & ~load_shift;
    assign start      = load_shift | pop;
    assign new_word   = pop ? hold_data : W'({bus.msg, bus.p});

    rce_word_hold #(.W(W)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (W'({bus.msg, bus.p})),
        .dout (hold_data),
        .full (hold_full)
    );

    // Next-state, counter and shift datapath.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        y_nx     = y_q;
        vld_nx   = vld_q;
        unique case (state)
            IDLE: begin
            end
            SEND_MSG: begin
                if (xfer) begin
                    y_nx  = sh[W-1];
                    sh_nx = {sh[W-2:0], 1'b0};
                    if (cnt == '0) begin
                        state_nx = SEND_PAR;
                        cnt_nx   = PAR_TOP;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
            SEND_PAR: begin
                if (xfer) begin
                    if (cnt == '0) begin
                        state_nx = IDLE;
                        vld_nx   = 1'b0;
                        y_nx     = 1'b0;
                    end else begin
                        y_nx   = sh[W-1];
                        sh_nx  = {sh[W-2:0], 1'b0};
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start) begin
            state_nx = SEND_MSG;
            cnt_nx   = MSG_TOP;
            y_nx     = new_word[W-1];
            sh_nx    = {new_word[W-2:0], 1'b0};
            vld_nx   = 1'b1;
        end
        last_nx = (state_nx == SEND_PAR) && (cnt_nx == '0);
    end

    // State and registered serial outputs; overflow is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            y_q    <= 1'b0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sh     <= sh_nx;
            y_q    <= y_nx;
            vld_q  <= vld_nx;
            last_q <= last_nx;
            if (bus.load && hold_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = vld_q;
    assign bus.y_last  = last_q;
    assign bus.ovf     = ovf_q;
    assign bus.ready   = ~hold_full;
    assign bus.busy    = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_rce_codeword_serializer.sv
// Directed bench for the codeword serializer with a bit-queue reference model.
module tb_rce_codeword_serializer;

    localparam int unsigned LM = 16;
    localparam int unsigned M  = 16;
    localparam int unsigned W  = LM + M;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rce_codeword_serializer_if #(.Lm(LM), .M(M)) bus ();

    rce_codeword_serializer #(.Lm(LM), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: queue of pending {bit, last} entries; hold slot full <=> more than one word queued.
    logic [1:0] mq[$];
    logic       m_ovf = 1'b0;

    always @(posedge clk or negedge rst) begin : model_b
        bit          rdy;
        logic [31:0] w;
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            rdy = (mq.size() <= W);
            w   = {bus.msg, bus.p};
            if (bus.load && !rdy) m_ovf = 1'b1;
            if (mq.size() > 0 && bus.y_ready) void'(mq.pop_front());
            if (bus.load && rdy) begin
                for (int i = 0; i < int'(W); i++) begin
                    mq.push_back({w[int'(W) - 1 - i], (i == int'(W) - 1)});
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    bit capq[$];
    int lastpos[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare();
        if (rst) begin
            chk1("y_valid", bus.y_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk1("y", bus.y, mq[0][1]);
                chk1("y_last", bus.y_last, mq[0][0]);
            end else begin
                chk1("y_idle", bus.y, 1'b0);
                chk1("y_last_idle", bus.y_last, 1'b0);
            end
            chk1("ready", bus.ready, mq.size() <= W);
            chk1("busy", bus.busy, mq.size() > 0);
            chk1("ovf", bus.ovf, m_ovf);
        end
    endtask

    // Record the bit about to transfer, advance one cycle, then compare.
    task automatic tick();
        if (rst && bus.y_valid && bus.y_ready) begin
            if (bus.y_last) lastpos.push_back(capq.size());
            capq.push_back(bus.y);
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_load(input logic [15:0] m, input logic [15:0] pp);
        bus.msg  = m;
        bus.p    = pp;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (bus.busy && n < maxc) begin
            tick();
            n++;
        end
        chk1({"timeout_", name}, bus.busy, 1'b0);
    endtask

    function automatic logic [31:0] capw(input int s);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) begin
            r = {r[30:0], (s + i < capq.size()) ? capq[s + i] : 1'b0};
        end
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int l;
        int n;
        int vc;
        int bc;
        int pat[4] = '{1, 0, 0, 1};

        rst         = 1'b0;
        bus.msg     = '0;
        bus.p       = '0;
        bus.load    = 1'b0;
        bus.y_ready = 1'b1;
        repeat (3) tick();
        chk1("rst_y_valid", bus.y_valid, 1'b0);
        chk1("rst_y", bus.y, 1'b0);
        chk1("rst_y_last", bus.y_last, 1'b0);
        chk1("rst_ready", bus.ready, 1'b1);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_ovf", bus.ovf, 1'b0);
        rst = 1'b1;
        tick();

        // Single word, continuous ready.
        s = capq.size();
        l = lastpos.size();
        do_load(16'hA5C3, 16'h0F0F);
        chk1("lat_valid", bus.y_valid, 1'b1);
        chk1("lat_y", bus.y, 1'b1);
        wait_idle(100, "single");
        chk32("single_stream", capw(s), 32'hA5C3_0F0F);
        chk32("single_count", capq.size() - s, 32);
        chk32("single_last_n", lastpos.size() - l, 1);
        chk32("single_last_pos", (lastpos.size() > l) ? lastpos[l] - s : -1, 31);

        // Back-to-back words: no bubble between them.
        s  = capq.size();
        vc = 0;
        bc = 0;
        do_load(16'hA5C3, 16'h0F0F);
        vc += int'(bus.y_valid);
        bc += int'(bus.busy);
        repeat (5) begin
            tick();
            vc += int'(bus.y_valid);
            bc += int'(bus.busy);
        end
        do_load(16'h1234, 16'hFFFF);
        vc += int'(bus.y_valid);
        bc += int'(bus.busy);
        chk1("b2b_ready_low", bus.ready, 1'b0);
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            vc += int'(bus.y_valid);
            bc += int'(bus.busy);
            n++;
        end
        chk1("timeout_b2b", bus.busy, 1'b0);
        chk32("b2b_valid_cycles", vc, 64);
        chk32("b2b_busy_cycles", bc, 64);
        chk32("b2b_word1", capw(s), 32'hA5C3_0F0F);
        chk32("b2b_word2", capw(s + 32), 32'h1234_FFFF);
        chk1("b2b_bit33", (s + 32 < capq.size()) ? capq[s + 32] : 1'b1, 1'b0);

        // Backpressure 1,0,0,1 repeating.
        s = capq.size();
        do_load(16'hA5C3, 16'h0F0F);
        n = 0;
        while (bus.busy && n < 400) begin
            bus.y_ready = pat[n % 4] != 0;
            tick();
            n++;
        end
        bus.y_ready = 1'b1;
        chk1("timeout_bp", bus.busy, 1'b0);
        chk32("bp_stream", capw(s), 32'hA5C3_0F0F);
        chk32("bp_count", capq.size() - s, 32);

        // Overflow: third load while hold slot is full.
        s = capq.size();
        do_load(16'hA5C3, 16'h0F0F);
        do_load(16'h1234, 16'hFFFF);
        chk1("ovf_ready_low", bus.ready, 1'b0);
        chk1("ovf_before", bus.ovf, 1'b0);
        do_load(16'hDEAD, 16'hBEEF);
        chk1("ovf_set", bus.ovf, 1'b1);
        wait_idle(200, "ovf");
        chk32("ovf_word1", capw(s), 32'hA5C3_0F0F);
        chk32("ovf_word2", capw(s + 32), 32'h1234_FFFF);
        chk32("ovf_count", capq.size() - s, 64);
        chk1("ovf_sticky", bus.ovf, 1'b1);

        // Reset in the middle of a codeword.
        do_load(16'h1234, 16'hFFFF);
        repeat (9) tick();
        rst = 1'b0;
        #1;
        chk1("mrst_y_valid", bus.y_valid, 1'b0);
        chk1("mrst_ready", bus.ready, 1'b1);
        chk1("mrst_ovf", bus.ovf, 1'b0);
        chk1("mrst_busy", bus.busy, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        s = capq.size();
        do_load(16'h1234, 16'hFFFF);
        wait_idle(100, "mrst");
        chk32("mrst_stream", capw(s), 32'h1234_FFFF);
        chk32("mrst_count", capq.size() - s, 32);

        // Load in the same cycle as the final parity bit transfers.
        s = capq.size();
        do_load(16'hA5C3, 16'h0F0F);
        n = 0;
        while (!bus.y_last && n < 100) begin
            tick();
            n++;
        end
        chk1("bnd_at_last", bus.y_last, 1'b1);
        chk1("bnd_ready_before", bus.ready, 1'b1);
        do_load(16'h1234, 16'hFFFF);
        chk1("bnd_ready_after", bus.ready, 1'b1);
        chk1("bnd_valid", bus.y_valid, 1'b1);
        chk1("bnd_y_msb", bus.y, 1'b0);
        chk1("bnd_y_last", bus.y_last, 1'b0);
        wait_idle(100, "bnd");
        chk32("bnd_word1", capw(s), 32'hA5C3_0F0F);
        chk32("bnd_word2", capw(s + 32), 32'h1234_FFFF);
        chk32("bnd_count", capq.size() - s, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
